line_arbiter: RTL

LINE_ARBITER -- requirements
Module: line_arbiter

---
 rtl/line_pkg.sv | 9 +
 rtl/rr_picker.sv | 16 +
 rtl/line_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/line_pkg.sv
// line_pkg: state encoding and default phase lengths shared by line_arbiter.
package line_pkg;
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, GAP} state_t;
  localparam int START_DEF = 5;
  localparam int HIGH_DEF = 20;
  localparam int LOW_DEF = 10;
  localparam int STOP_DEF = 15;
  localparam int GAP_DEF = 4;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: 4-way round-robin pick, searching upward from ptr with wrap.
module rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);
  logic [1:0] k;
  always_comb begin
    grant = '0;
    k = '0;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) grant = 4'b0001 << k;
    end
  end
endmodule

// File: rtl/line_arbiter.sv
// line_arbiter: grants one of four requesters round-robin and sends its byte
// MSB first as start-low / width-coded-high pulses on a shared idle-high line.
module line_arbiter
  import line_pkg::*;
#(
  parameter int START_PERIOD = START_DEF,
  parameter int HIGH_PERIOD = HIGH_DEF,
  parameter int LOW_PERIOD = LOW_DEF,
  parameter int STOP_PERIOD = STOP_DEF,
  parameter int GAP_PERIOD = GAP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic        sg_out,
  output logic        bus_held,
  output logic [1:0]  grant_id,
  output logic        frame_done,
  output logic        busy
);
  state_t state, state_nxt;
  logic [7:0] cnt, last_cnt, shreg;
  logic [2:0] bit_idx;
  logic [1:0] ptr, win_id;
  logic [3:0] grant;
  logic phase_end;
  rr_picker u_pick (.req(req_valid), .ptr(ptr), .grant(grant));
  always_comb begin
    win_id = '0;
    for (int i = 0; i < 4; i++) if (grant[i]) win_id = 2'(i);
  end
  always_comb begin
    last_cnt = state == START ? 8'(START_PERIOD - 1) :
               state == BIT   ? (shreg[7] ? 8'(HIGH_PERIOD - 1) : 8'(LOW_PERIOD - 1)) :
               state == STOP  ? 8'(STOP_PERIOD - 1) : 8'(GAP_PERIOD - 1);
    phase_end = cnt == last_cnt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = START;
      START:   if (phase_end) state_nxt = BIT;
      BIT:     if (phase_end) state_nxt = bit_idx == 3'd0 ? STOP : START;
      STOP:    if (phase_end) state_nxt = GAP;
      GAP:     if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      ptr <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state_nxt != state || state == IDLE) ? '0 : cnt + 8'd1;
      if (state == IDLE && |req_valid) begin
        shreg <= req_data[{win_id, 3'b000} +: 8];
        grant_id <= win_id;
        ptr <= win_id + 2'd1;
        bit_idx <= 3'd7;
      end
      if (state == BIT && phase_end) begin
        shreg <= shreg << 1;
        bit_idx <= bit_idx - 3'd1;
      end
    end
  end
  // Line outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sg_out <= 1'b1;
      bus_held <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      sg_out <= !(state_nxt == START || state_nxt == STOP);
      bus_held <= state_nxt inside {START, BIT, STOP};
      frame_done <= state == STOP && state_nxt == GAP;
    end
  end
  always_comb begin
    req_ready = (rst_n && state == IDLE) ? grant : '0;
    busy = state != IDLE;
  end
endmodule
